// File: rtl/out_port_arbiter.sv
// Output-port arbiter: round-robin read grant, credit-protected capture FIFO, leaf link handshake.
// Optional accepted-packet counter enabled by defining OUT_ARB_PKT_CNT_EN.
module out_port_arbiter #(
  parameter int PACKET_BITS   = 97,
  parameter int NUM_OUT_PORTS = 8,
  parameter int BUF_DEPTH     = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_OUT_PORTS-1:0]               port_empty,
  input  logic [NUM_OUT_PORTS*PACKET_BITS-1:0]   port_packet,
  output logic [NUM_OUT_PORTS-1:0]               rd_en_sel,
  output logic [PACKET_BITS-1:0]                 dout_leaf2bft,
  output logic                                   vld_leaf2bft,
  input  logic                                   ack_bft2leaf,
  output logic                                   err_multi,
  output logic [31:0]                            pkt_count
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int PW = $clog2(NUM_OUT_PORTS);
  localparam logic [PW-1:0] LAST_PORT = PW'(NUM_OUT_PORTS - 1);
  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(BUF_DEPTH);
  localparam logic [PW:0]   NPORTS_W  = (PW+1)'(NUM_OUT_PORTS);

  logic [PACKET_BITS-1:0] mem_q [BUF_DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [AW:0]            occ_q, occ_d;
  logic                   inflight_q;
  logic [PW-1:0]          last_grant_q, last_grant_d;
  logic                   err_q;

  logic                     credit, found, grant;
  logic                     push, pop, multi, full;
  logic [PW-1:0]            gnt_idx;
  logic [PACKET_BITS-1:0]   merged;
  logic [NUM_OUT_PORTS-1:0] pkt_vld;

  // A grant reserves a slot for the packet arriving next cycle.
  assign credit = (occ_q + {{AW{1'b0}}, inflight_q}) < DEPTH_W;

  always_comb begin
    logic [PW:0] idx;
    idx     = '0;
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= NUM_OUT_PORTS; k++) begin
      idx = {1'b0, last_grant_q} + (PW+1)'(k);
      if (idx >= NPORTS_W) idx = idx - NPORTS_W;
      if (!found && !port_empty[idx[PW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    rd_en_sel = '0;
    if (!reset && found && credit) rd_en_sel[gnt_idx] = 1'b1;
  end

  assign grant        = |rd_en_sel;
  assign last_grant_d = grant ? gnt_idx : last_grant_q;

  always_comb begin
    merged  = '0;
    pkt_vld = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      merged     = merged | port_packet[i*PACKET_BITS +: PACKET_BITS];
      pkt_vld[i] = port_packet[i*PACKET_BITS + PACKET_BITS - 1];
    end
  end

  assign push  = |pkt_vld;
  assign multi = (pkt_vld & (pkt_vld - NUM_OUT_PORTS'(1))) != '0;
  assign full  = occ_q == DEPTH_W;

  assign vld_leaf2bft  = occ_q != '0;
  assign pop           = vld_leaf2bft && ack_bft2leaf;
  assign dout_leaf2bft = vld_leaf2bft ? mem_q[rd_ptr_q] : '0;
  assign err_multi     = err_q;

  assign occ_d = occ_q + (AW+1)'(push) - (AW+1)'(pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      inflight_q   <= 1'b0;
      last_grant_q <= LAST_PORT;
      err_q        <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      occ_q        <= occ_d;
      inflight_q   <= grant;
      last_grant_q <= last_grant_d;
      if (multi) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= merged;
  end

`ifdef OUT_ARB_PKT_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    cnt_q <= '0;
    else if (pop) cnt_q <= cnt_q + 32'd1;
  end

  assign pkt_count = cnt_q;
`else
  assign pkt_count = 32'd0;
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: tb/tb_out_port_arbiter.sv
// Directed bench for out_port_arbiter: port model, scoreboard of pushed packets,
// hand-computed grant orders and link outputs.
module tb_out_port_arbiter;

  localparam int PB = 97;
  localparam int NP = 8;

  localparam logic [7:0] RR_EXP [6] = '{8'h08, 8'h20, 8'h01, 8'h08, 8'h20, 8'h01};
  localparam int         RR_P   [6] = '{3, 5, 0, 3, 5, 0};
  localparam int         RR_S   [6] = '{0, 0, 0, 1, 1, 1};
  localparam logic [7:0] BP_EXP [6] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h00, 8'h00};

  logic             clk = 1'b0;
  logic             reset;
  logic [NP-1:0]    port_empty;
  logic [NP*PB-1:0] port_packet;
  logic [NP-1:0]    rd_en_sel;
  logic [PB-1:0]    dout;
  logic             vld;
  logic             ack;
  logic             err;
  logic [31:0]      pcnt;

  always #5 clk = ~clk;

  out_port_arbiter #(
    .PACKET_BITS  (PB),
    .NUM_OUT_PORTS(NP),
    .BUF_DEPTH    (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .port_empty   (port_empty),
    .port_packet  (port_packet),
    .rd_en_sel    (rd_en_sel),
    .dout_leaf2bft(dout),
    .vld_leaf2bft (vld),
    .ack_bft2leaf (ack),
    .err_multi    (err),
    .pkt_count    (pcnt)
  );

  int            n_cmp = 0;
  int            n_bad = 0;
  int            cnt [NP];
  int            seq [NP];
  logic [NP-1:0] null_mask;
  logic [NP*PB-1:0] inj;
  logic [PB-1:0] sent [$];
  int            npop;
  int            np0;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PB-1:0] mkpkt(int p, int n);
    return {1'b1, 64'd0, 16'(p), 16'(n)};
  endfunction

  function automatic logic [31:0] exp_cnt();
`ifdef OUT_ARB_PKT_CNT_EN
    return 32'(npop);
`else
    return 32'd0;
`endif
  endfunction

  task automatic set_port(int p, int n);
    cnt[p] = n;
    port_empty[p] = (n == 0);
  endtask

  // Advance one cycle: a port granted this cycle emits its packet next cycle.
  task automatic tick();
    logic [NP-1:0] g;
    g = rd_en_sel;
    if (vld && ack) begin
      chk("sb_nonempty", 128'(sent.size() != 0), 128'd1);
      if (sent.size() != 0) chk("pop_data", dout, sent.pop_front());
      npop++;
    end
    @(posedge clk);
    #1;
    port_packet = inj;
    for (int i = 0; i < NP; i++) begin
      if (g[i]) begin
        if (!null_mask[i]) begin
          port_packet[i*PB +: PB] = mkpkt(i, seq[i]);
          sent.push_back(mkpkt(i, seq[i]));
          seq[i]++;
        end
        if (cnt[i] > 0) cnt[i]--;
        port_empty[i] = (cnt[i] == 0);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset       = 1'b1;
    ack         = 1'b0;
    port_empty  = '1;
    port_packet = '0;
    inj         = '0;
    null_mask   = '0;
    npop        = 0;
    for (int i = 0; i < NP; i++) begin
      cnt[i] = 0;
      seq[i] = 0;
    end
    #23 reset = 1'b0;
    @(negedge clk);

    chk("rst_rd", rd_en_sel, 0);
    chk("rst_vld", vld, 0);
    chk("rst_dout", dout, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", pcnt, 0);

    // single port
    set_port(2, 1);
    ack = 1'b1;
    #1;
    chk("t1_grant", rd_en_sel, 8'h04);
    tick();
    chk("t1_rd_off", rd_en_sel, 0);
    chk("t1_vld_early", vld, 0);
    tick();
    chk("t1_vld", vld, 1);
    chk("t1_dout", dout, mkpkt(2, 0));
    tick();
    chk("t1_idle", vld, 0);

    // round robin, one packet per cycle
    set_port(0, -1);
    set_port(3, -1);
    set_port(5, -1);
    #1;
    for (int k = 0; k < 6; k++) begin
      chk("t2_grant", rd_en_sel, RR_EXP[k]);
      if (k >= 2) begin
        chk("t2_vld", vld, 1);
        chk("t2_dout", dout, mkpkt(RR_P[k-2], RR_S[k-2]));
      end
      tick();
    end
    set_port(0, 0);
    set_port(3, 0);
    set_port(5, 0);
    #1;
    chk("t2_stop", rd_en_sel, 0);
    for (int k = 0; k < 4; k++) tick();
    chk("t2_idle", vld, 0);
    chk("t2_cnt", pcnt, exp_cnt());

    // backpressure
    ack = 1'b0;
    for (int i = 0; i < NP; i++) set_port(i, -1);
    #1;
    for (int k = 0; k < 6; k++) begin
      chk("t3_grant", rd_en_sel, BP_EXP[k]);
      tick();
    end
    chk("t3_vld", vld, 1);
    chk("t3_dout", dout, mkpkt(1, 0));
    tick();
    tick();
    chk("t3_hold_rd", rd_en_sel, 0);
    chk("t3_stable", dout, mkpkt(1, 0));
    for (int i = 0; i < NP; i++) set_port(i, 0);
    ack = 1'b1;
    np0 = npop;
    for (int k = 0; k < 6; k++) tick();
    chk("t3_drained", 128'(npop - np0), 128'd4);
    chk("t3_idle", vld, 0);
    chk("t3_sb_left", 128'(sent.size()), 128'd0);
    chk("t3_cnt", pcnt, exp_cnt());

    // null grant
    null_mask[1] = 1'b1;
    set_port(1, 1);
    set_port(2, 1);
    #1;
    chk("t4_grant1", rd_en_sel, 8'h02);
    tick();
    chk("t4_grant2", rd_en_sel, 8'h04);
    tick();
    chk("t4_nopush", vld, 0);
    tick();
    chk("t4_vld", vld, 1);
    chk("t4_dout", dout, mkpkt(2, 2));
    tick();
    chk("t4_idle", vld, 0);
    chk("t4_noerr", err, 0);
    null_mask = '0;

    // multiple valid bits in one cycle
    ack = 1'b0;
    inj[0*PB +: PB] = {1'b1, 96'hA};
    inj[4*PB +: PB] = {1'b1, 96'h5};
    sent.push_back({1'b1, 96'hF});
    tick();
    inj = '0;
    tick();
    chk("t5_err", err, 1);
    chk("t5_vld", vld, 1);
    chk("t5_merged", dout, {1'b1, 96'hF});
    ack = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk("t5_sticky", err, 1);
    chk("t5_idle", vld, 0);

    // reset with three packets buffered
    ack = 1'b0;
    set_port(5, 1);
    set_port(6, 1);
    set_port(7, 1);
    #1;
    chk("t6_grant", rd_en_sel, 8'h20);
    for (int k = 0; k < 4; k++) tick();
    chk("t6_buf_vld", vld, 1);
    chk("t6_buf_rd", rd_en_sel, 0);
    #2;
    reset = 1'b1;
    set_port(0, 1);
    set_port(3, 1);
    #1;
    chk("t6_rst_vld", vld, 0);
    chk("t6_rst_rd", rd_en_sel, 0);
    chk("t6_rst_dout", dout, 0);
    chk("t6_rst_cnt", pcnt, 0);
    chk("t6_rst_err", err, 0);
    sent.delete();
    npop = 0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t6_prio", rd_en_sel, 8'h01);
    tick();
    chk("t6_next", rd_en_sel, 8'h08);
    ack = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk("t6_idle", vld, 0);
    chk("t6_sb_left", 128'(sent.size()), 128'd0);
    chk("t6_cnt", pcnt, exp_cnt());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
